// File: rtl/dmem_req_ctrl.sv
// Data-side memory request controller: issues EX loads/stores on an SRAM-like
// bus, tracks in-order responses, drops flushed ones and buffers load data for MEM.
module dmem_req_ctrl #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req_valid,
  output logic        ex_req_ready,
  input  logic        ex_req_wr,
  input  logic [1:0]  ex_req_size,
  input  logic [31:0] ex_req_addr,
  input  logic [3:0]  ex_req_wstrb,
  input  logic [31:0] ex_req_wdata,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        read_data_out_req,
  output logic [31:0] read_data,
  input  logic        mem_rd_take,
  input  logic        excp_flush,
  input  logic        ertn_flush
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {
    IDLE,
    REQ
  } state_e;

  state_e        state_q;
  logic          req_q;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;
  logic          cancel_req_q;

  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] live_rd_q, live_rd_d;
  logic [CW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CW:0]   rd_load;

  logic [MAX_OUT-1:0] ord_rd_q;
  logic [MAX_OUT-1:0] ord_cancel_q;
  logic [PW-1:0]      ord_wp_q, ord_rp_q;

  logic [31:0]   rsp_mem_q [MAX_OUT];
  logic [PW-1:0] rsp_wp_q, rsp_rp_q;

  logic flush;
  logic accept;
  logic addr_hs;
  logic rsp_v;
  logic rsp_live;
  logic rsp_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(MAX_OUT - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign flush    = excp_flush | ertn_flush;
  assign rd_load  = {1'b0, live_rd_q} + {1'b0, rsp_cnt_q};

  // Loads also need a guaranteed slot in the response FIFO before they issue.
  assign ex_req_ready = (state_q == IDLE) && !flush &&
                        (out_cnt_q < CW'(MAX_OUT)) &&
                        (ex_req_wr || (rd_load < (CW + 1)'(MAX_OUT)));

  assign accept   = ex_req_valid && ex_req_ready;
  assign addr_hs  = (state_q == REQ) && data_sram_addr_ok;
  assign rsp_v    = data_sram_data_ok && (out_cnt_q != '0);
  assign rsp_live = rsp_v && ord_rd_q[ord_rp_q] && !ord_cancel_q[ord_rp_q] && !flush;
  assign rsp_pop  = mem_rd_take && (rsp_cnt_q != '0);

  assign data_sram_req     = req_q;
  assign data_sram_wr      = wr_q;
  assign data_sram_size    = size_q;
  assign data_sram_addr    = addr_q;
  assign data_sram_wstrb   = wstrb_q;
  assign data_sram_wdata   = wdata_q;
  assign read_data_out_req = (rsp_cnt_q != '0);
  assign read_data         = rsp_mem_q[rsp_rp_q];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      cancel_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cancel_req_q <= 1'b0;
          if (accept) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            wr_q    <= ex_req_wr;
            size_q  <= ex_req_size;
            addr_q  <= ex_req_addr;
            wstrb_q <= ex_req_wstrb;
            wdata_q <= ex_req_wdata;
          end
        end
        REQ: begin
          // The request stays on the bus through a flush; only its response is dropped.
          if (flush) cancel_req_q <= 1'b1;
          if (data_sram_addr_ok) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            cancel_req_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    out_cnt_d = out_cnt_q;
    live_rd_d = live_rd_q;
    rsp_cnt_d = rsp_cnt_q;

    case ({addr_hs, rsp_v})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    if (flush) begin
      live_rd_d = '0;
      rsp_cnt_d = '0;
    end else begin
      case ({accept && !ex_req_wr, rsp_live})
        2'b10:   live_rd_d = live_rd_q + 1'b1;
        2'b01:   live_rd_d = live_rd_q - 1'b1;
        default: live_rd_d = live_rd_q;
      endcase
      case ({rsp_live, rsp_pop})
        2'b10:   rsp_cnt_d = rsp_cnt_q + 1'b1;
        2'b01:   rsp_cnt_d = rsp_cnt_q - 1'b1;
        default: rsp_cnt_d = rsp_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt_q <= '0;
      live_rd_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      live_rd_q <= live_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
    end
  end

  // Order FIFO: one {is_rd, cancel} entry per request past addr_ok.
  always_ff @(posedge clk) begin
    if (reset) begin
      ord_wp_q     <= '0;
      ord_rp_q     <= '0;
      ord_cancel_q <= '0;
    end else begin
      if (flush) ord_cancel_q <= ord_cancel_q | {MAX_OUT{1'b1}};
      if (addr_hs) begin
        ord_rd_q[ord_wp_q]     <= !wr_q;
        ord_cancel_q[ord_wp_q] <= cancel_req_q | flush;
        ord_wp_q               <= ptr_inc(ord_wp_q);
      end
      if (rsp_v) ord_rp_q <= ptr_inc(ord_rp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_wp_q <= '0;
      rsp_rp_q <= '0;
    end else if (flush) begin
      rsp_wp_q <= '0;
      rsp_rp_q <= '0;
    end else begin
      if (rsp_live) rsp_wp_q <= ptr_inc(rsp_wp_q);
      if (rsp_pop)  rsp_rp_q <= ptr_inc(rsp_rp_q);
    end
  end

  // NOTE: the data storage is not reset; rsp_cnt_q alone says which slots are valid.
  always_ff @(posedge clk) begin
    if (rsp_live) rsp_mem_q[rsp_wp_q] <= data_sram_rdata;
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    data_sram_data_ok |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: linear stimulus, hand-computed expectations,
// immediate assertions at each comparison point.
module tb_dmem_req_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_req_valid;
  logic        ex_req_ready;
  logic        ex_req_wr;
  logic [1:0]  ex_req_size;
  logic [31:0] ex_req_addr;
  logic [3:0]  ex_req_wstrb;
  logic [31:0] ex_req_wdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        read_data_out_req;
  logic [31:0] read_data;
  logic        mem_rd_take;
  logic        excp_flush;
  logic        ertn_flush;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_req_ctrl #(.MAX_OUT(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_req_valid      (ex_req_valid),
    .ex_req_ready      (ex_req_ready),
    .ex_req_wr         (ex_req_wr),
    .ex_req_size       (ex_req_size),
    .ex_req_addr       (ex_req_addr),
    .ex_req_wstrb      (ex_req_wstrb),
    .ex_req_wdata      (ex_req_wdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .read_data_out_req (read_data_out_req),
    .read_data         (read_data),
    .mem_rd_take       (mem_rd_take),
    .excp_flush        (excp_flush),
    .ertn_flush        (ertn_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 2 ns after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata);
    ex_req_valid = 1'b1;
    ex_req_wr    = wr;
    ex_req_size  = 2'd2;
    ex_req_addr  = addr;
    ex_req_wstrb = strb;
    ex_req_wdata = wdata;
  endtask

  initial begin
    reset = 1'b1;
    ex_req_valid = 1'b0; ex_req_wr = 1'b0; ex_req_size = '0; ex_req_addr = '0;
    ex_req_wstrb = '0; ex_req_wdata = '0; data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; mem_rd_take = 1'b0;
    excp_flush = 1'b0; ertn_flush = 1'b0;
    step(); step();
    check("rst_req", 32'(data_sram_req), 32'd0);
    check("rst_addr", data_sram_addr, 32'd0);
    check("rst_wdata", data_sram_wdata, 32'd0);
    check("rst_out_req", 32'(read_data_out_req), 32'd0);
    check("rst_out_cnt", 32'(dut.out_cnt_q), 32'd0);
    reset = 1'b0;

    // Single load, addr_ok in cycle 3, data_ok in cycle 5
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    #1 check("t1_ready", 32'(ex_req_ready), 32'd1);
    step(); ex_req_valid = 1'b0;
    check("t1_req_c1", 32'(data_sram_req), 32'd1);
    check("t1_addr_c1", data_sram_addr, 32'h1000);
    check("t1_wr_c1", 32'(data_sram_wr), 32'd0);
    step();
    check("t1_req_c2", 32'(data_sram_req), 32'd1);
    check("t1_addr_c2", data_sram_addr, 32'h1000);
    step();
    check("t1_req_c3", 32'(data_sram_req), 32'd1);
    check("t1_addr_c3", data_sram_addr, 32'h1000);
    check("t1_busy_ready", 32'(ex_req_ready), 32'd0);
    data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    check("t1_req_c4", 32'(data_sram_req), 32'd0);
    check("t1_out_cnt", 32'(dut.out_cnt_q), 32'd1);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
    check("t1_out_req_c5", 32'(read_data_out_req), 32'd0);
    step(); data_sram_data_ok = 1'b0;
    check("t1_out_req_c6", 32'(read_data_out_req), 32'd1);
    check("t1_rdata_c6", read_data, 32'hDEADBEEF);
    check("t1_out_cnt_done", 32'(dut.out_cnt_q), 32'd0);
    step();
    check("t1_out_req_c7", 32'(read_data_out_req), 32'd1);
    check("t1_rdata_c7", read_data, 32'hDEADBEEF);
    mem_rd_take = 1'b1;
    step(); mem_rd_take = 1'b0;
    check("t1_popped", 32'(read_data_out_req), 32'd0);

    // Store with immediate addr_ok
    issue(1'b1, 32'h2004, 4'hF, 32'h12345678);
    step(); ex_req_valid = 1'b0;
    check("t2_req", 32'(data_sram_req), 32'd1);
    check("t2_wr", 32'(data_sram_wr), 32'd1);
    check("t2_addr", data_sram_addr, 32'h2004);
    check("t2_wstrb", 32'(data_sram_wstrb), 32'hF);
    check("t2_wdata", data_sram_wdata, 32'h12345678);
    check("t2_size", 32'(data_sram_size), 32'd2);
    data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    check("t2_req_drop", 32'(data_sram_req), 32'd0);
    check("t2_out_cnt1", 32'(dut.out_cnt_q), 32'd1);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE0000;
    step(); data_sram_data_ok = 1'b0;
    check("t2_no_out_req", 32'(read_data_out_req), 32'd0);
    check("t2_out_cnt0", 32'(dut.out_cnt_q), 32'd0);

    // Two loads buffered while MEM stalls; the third is held off
    issue(1'b0, 32'h3000, 4'h0, 32'h0);
    step(); ex_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    issue(1'b0, 32'h3004, 4'h0, 32'h0);
    #1 check("t3_ready_2nd", 32'(ex_req_ready), 32'd1);
    step(); ex_req_valid = 1'b0;
    check("t3_addr_2nd", data_sram_addr, 32'h3004);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11;
    step(); data_sram_addr_ok = 1'b0; data_sram_rdata = 32'h22;
    check("t3_out_cnt_mid", 32'(dut.out_cnt_q), 32'd1);
    step(); data_sram_data_ok = 1'b0;
    check("t3_rsp_cnt_full", 32'(dut.rsp_cnt_q), 32'd2);
    issue(1'b0, 32'h3008, 4'h0, 32'h0);
    #1 check("t3_ready_blocked", 32'(ex_req_ready), 32'd0);
    check("t3_head_11", read_data, 32'h11);
    mem_rd_take = 1'b1;
    step(); mem_rd_take = 1'b0;
    check("t3_head_22", read_data, 32'h22);
    check("t3_no_accept_yet", 32'(data_sram_req), 32'd0);
    #1 check("t3_ready_freed", 32'(ex_req_ready), 32'd1);
    mem_rd_take = 1'b1;
    step(); ex_req_valid = 1'b0; mem_rd_take = 1'b0;
    check("t3_third_req", 32'(data_sram_req), 32'd1);
    check("t3_third_addr", data_sram_addr, 32'h3008);
    check("t3_fifo_empty", 32'(read_data_out_req), 32'd0);
    data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h33;
    step(); data_sram_data_ok = 1'b0;
    check("t3_third_data", read_data, 32'h33);
    mem_rd_take = 1'b1;
    step(); mem_rd_take = 1'b0;
    check("t3_drained", 32'(read_data_out_req), 32'd0);

    // Flush the cycle after addr_ok; the response must be discarded
    issue(1'b0, 32'h4000, 4'h0, 32'h0);
    step(); ex_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0; excp_flush = 1'b1;
    #1 check("t4_flush_ready", 32'(ex_req_ready), 32'd0);
    step(); excp_flush = 1'b0;
    check("t4_live_rd_clr", 32'(dut.live_rd_q), 32'd0);
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA;
    step(); data_sram_data_ok = 1'b0;
    check("t4_dropped", 32'(read_data_out_req), 32'd0);
    check("t4_out_cnt0", 32'(dut.out_cnt_q), 32'd0);

    // Flush while waiting for addr_ok: request held, entry cancelled
    issue(1'b0, 32'h5000, 4'h0, 32'h0);
    step(); ex_req_valid = 1'b0; ertn_flush = 1'b1;
    step(); ertn_flush = 1'b0;
    check("t5_req_held", 32'(data_sram_req), 32'd1);
    check("t5_addr_held", data_sram_addr, 32'h5000);
    check("t5_cancel_req", 32'(dut.cancel_req_q), 32'd1);
    step();
    check("t5_req_held_c3", 32'(data_sram_req), 32'd1);
    data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    check("t5_req_drop", 32'(data_sram_req), 32'd0);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBAD0BAD0;
    step(); data_sram_data_ok = 1'b0;
    check("t5_dropped", 32'(read_data_out_req), 32'd0);
    check("t5_out_cnt0", 32'(dut.out_cnt_q), 32'd0);
    issue(1'b0, 32'h5004, 4'h0, 32'h0);
    step(); ex_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55;
    step(); data_sram_data_ok = 1'b0;
    check("t5_next_out_req", 32'(read_data_out_req), 32'd1);
    check("t5_next_data", read_data, 32'h55);
    mem_rd_take = 1'b1;
    step(); mem_rd_take = 1'b0;

    // Same-cycle addr_ok and data_ok, plus a take on an empty FIFO
    issue(1'b0, 32'h6000, 4'h0, 32'h0);
    step(); ex_req_valid = 1'b0; data_sram_addr_ok = 1'b1;
    step(); data_sram_addr_ok = 1'b0;
    issue(1'b0, 32'h6004, 4'h0, 32'h0);
    step(); ex_req_valid = 1'b0;
    check("t6_empty_before", 32'(read_data_out_req), 32'd0);
    data_sram_addr_ok = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h77;
    mem_rd_take = 1'b1;
    step(); data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; mem_rd_take = 1'b0;
    check("t6_out_cnt_same", 32'(dut.out_cnt_q), 32'd1);
    check("t6_rsp_cnt", 32'(dut.rsp_cnt_q), 32'd1);
    check("t6_head_77", read_data, 32'h77);
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h88;
    step(); data_sram_data_ok = 1'b0;
    check("t6_rsp_cnt2", 32'(dut.rsp_cnt_q), 32'd2);
    check("t6_head_still_77", read_data, 32'h77);
    check("t6_out_cnt0", 32'(dut.out_cnt_q), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
